// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: generates a registered 50%-duty cpu_clk from sys_clk with a
// run-time programmable half-period. Supports free-run and debounced
// single-step operation, honours the CPU halt request, never truncates a
// phase, and provides rise/fall strobes plus a rising-edge counter.
//
// state | meaning
// STOP  | cpu_clk parked low; waiting for run mode or an accepted step press
// HIGH  | cpu_clk high phase, lasts hp+1 sys_clk cycles
// LOW   | cpu_clk low phase, lasts hp+1 sys_clk cycles; always follows HIGH

module cpu_clock_ctrl #(
    parameter int unsigned DIV_WIDTH = 24,
    parameter int unsigned DB_CYCLES = 250000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 mode,
    input  logic                 step_btn,
    input  logic                 halt,
    input  logic [DIV_WIDTH-1:0] half_period,
    output logic                 cpu_clk,
    output logic                 clk_rise,
    output logic                 clk_fall,
    output logic                 running,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam int unsigned     DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // button path
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            db_level_q, db_level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_press;

    // clock FSM
    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   phase_cnt_q, phase_cnt_d;
    logic                   step_req_q, step_req_d;
    logic                   start;
    logic                   cpu_clk_q, cpu_clk_d;
    logic                   clk_rise_q, clk_rise_d;
    logic                   clk_fall_q, clk_fall_d;
    logic                   running_q, running_d;
    logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;

    // Synchronise the raw button and accept a level change only after it has
    // persisted for DB_CYCLES consecutive cycles; a bounce restarts the count.
    always_comb begin
        sync1_d    = step_btn;
        sync2_d    = sync1_q;
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        db_press   = 1'b0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
                db_press   = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Button synchroniser and debouncer registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    // Next state, phase timer and registered outputs. The phase timer is a
    // down-counter loaded with half_period on every phase entry, so a new
    // half_period only matters at a phase boundary. Outputs are derived from
    // the next state so they line up with the state register.
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        step_req_d  = step_req_q;
        start       = !halt && (!mode || step_req_q);

        case (state_q)
            ST_STOP: begin
                phase_cnt_d = '0;
                // presses are only latched while parked in step mode
                if (db_press && mode) begin
                    step_req_d = 1'b1;
                end
                if (start) begin
                    state_d     = ST_HIGH;
                    phase_cnt_d = half_period;
                    step_req_d  = 1'b0;
                end
            end
            ST_HIGH: begin
                if (phase_cnt_q == '0) begin
                    state_d     = ST_LOW;
                    phase_cnt_d = half_period;
                end else begin
                    phase_cnt_d = phase_cnt_q - DIV_WIDTH'(1);
                end
            end
            ST_LOW: begin
                if (phase_cnt_q == '0) begin
                    if (!mode && !halt) begin
                        state_d     = ST_HIGH;
                        phase_cnt_d = half_period;
                    end else begin
                        state_d     = ST_STOP;
                        phase_cnt_d = '0;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q - DIV_WIDTH'(1);
                end
            end
            default: begin
                state_d     = ST_STOP;
                phase_cnt_d = '0;
            end
        endcase

        cpu_clk_d     = (state_d == ST_HIGH);
        clk_rise_d    = (state_d == ST_HIGH) && (state_q != ST_HIGH);
        clk_fall_d    = (state_d == ST_LOW) && (state_q != ST_LOW);
        running_d     = (state_d != ST_STOP);
        cycle_count_d = clk_rise_d ? cycle_count_q + CNT_WIDTH'(1) : cycle_count_q;
    end

    // Clock FSM state and output registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q       <= ST_STOP;
            phase_cnt_q   <= '0;
            step_req_q    <= 1'b0;
            cpu_clk_q     <= 1'b0;
            clk_rise_q    <= 1'b0;
            clk_fall_q    <= 1'b0;
            running_q     <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            phase_cnt_q   <= phase_cnt_d;
            step_req_q    <= step_req_d;
            cpu_clk_q     <= cpu_clk_d;
            clk_rise_q    <= clk_rise_d;
            clk_fall_q    <= clk_fall_d;
            running_q     <= running_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cpu_clk     = cpu_clk_q;
    assign clk_rise    = clk_rise_q;
    assign clk_fall    = clk_fall_q;
    assign running     = running_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Testbench for cpu_clock_ctrl: stimulus pushes expected clock events
// (rise / fall / stop, with phase length and cycle count) into a queue and
// a negedge monitor pops and compares each event the DUT produces.

module tb_cpu_clock_ctrl;

    localparam int DIV_W = 8;
    localparam int CNT_W = 4;
    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_STOP = 2;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             mode;
    logic             step_btn;
    logic             halt;
    logic [DIV_W-1:0] half_period;
    logic             cpu_clk;
    logic             clk_rise;
    logic             clk_fall;
    logic             running;
    logic [CNT_W-1:0] cycle_count;

    typedef struct {
        int kind;
        int len;   // length of the phase that just ended, -1 = don't care
        int cnt;
    } ev_t;

    ev_t sb_q[$];
    int  tests_run = 0;
    int  fails     = 0;

    // monitor-private state
    int   mon_len;
    logic mon_prev_run;
    logic mon_prev_clk;

    cpu_clock_ctrl #(
        .DIV_WIDTH(DIV_W),
        .DB_CYCLES(4),
        .CNT_WIDTH(CNT_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .mode       (mode),
        .step_btn   (step_btn),
        .halt       (halt),
        .half_period(half_period),
        .cpu_clk    (cpu_clk),
        .clk_rise   (clk_rise),
        .clk_fall   (clk_fall),
        .running    (running),
        .cycle_count(cycle_count)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: on every negedge, detect clock events and score them.
    always @(negedge sys_clk) begin
        int   kind;
        bit   have;
        bit   ok;
        ev_t  e;
        if (!sys_rst_n) begin
            mon_len      = 0;
            mon_prev_run = 1'b0;
            mon_prev_clk = 1'b0;
        end else begin
            mon_len++;
            have = 1'b0;
            kind = K_STOP;
            if (clk_rise) begin
                kind = K_RISE; have = 1'b1;
            end else if (clk_fall) begin
                kind = K_FALL; have = 1'b1;
            end else if (mon_prev_run && !running) begin
                kind = K_STOP; have = 1'b1;
            end
            if (have) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got kind=%0d len=%0d cnt=%0d, expected no event",
                             kind, mon_len, cycle_count);
                end else begin
                    e  = sb_q.pop_front();
                    ok = (e.kind == kind) && (e.len < 0 || e.len == mon_len) &&
                         (e.cnt == int'(cycle_count)) &&
                         (cpu_clk == (kind == K_RISE)) && (running == (kind != K_STOP));
                    if (!ok) begin
                        fails++;
                        $display("FAIL event: got kind=%0d len=%0d cnt=%0d clk=%0d run=%0d, expected kind=%0d len=%0d cnt=%0d",
                                 kind, mon_len, cycle_count, cpu_clk, running, e.kind, e.len, e.cnt);
                    end
                end
                mon_len = 0;
            end else begin
                tests_run++;
                if (cpu_clk != mon_prev_clk) begin
                    fails++;
                    $display("FAIL glitch: cpu_clk=%0d changed without a strobe, expected %0d",
                             cpu_clk, mon_prev_clk);
                end
            end
            mon_prev_run = running;
            mon_prev_clk = cpu_clk;
        end
    end

    task automatic push_ev(input int k, input int l, input int c);
        ev_t e;
        e.kind = k;
        e.len  = l;
        e.cnt  = c;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    // Wait until at most n expected events remain, bounded by budget cycles.
    task automatic wait_q(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (sb_q.size() > n && k < budget) begin
            tick(1);
            k++;
        end
        tests_run++;
        if (sb_q.size() > n) begin
            fails++;
            $display("FAIL %s: timeout with %0d events pending, expected <= %0d", name, sb_q.size(), n);
            sb_q.delete();
        end
    endtask

    // Assert reset for two cycles, check the reset state, then release.
    task automatic do_reset(input logic m, input logic [DIV_W-1:0] hp, input logic h);
        mode        = m;
        half_period = hp;
        halt        = h;
        step_btn    = 1'b0;
        sys_rst_n   = 1'b0;
        tick(1);
        chk("rst_cpu_clk", cpu_clk, 0);
        chk("rst_clk_rise", clk_rise, 0);
        chk("rst_clk_fall", clk_fall, 0);
        chk("rst_running", running, 0);
        chk("rst_cycle_count", cycle_count, 0);
        tick(1);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        sys_rst_n   = 1'b0;
        mode        = 1'b0;
        step_btn    = 1'b0;
        halt        = 1'b1;
        half_period = '0;

        // free run, hp=3: five periods of 4/4, then halt mid-HIGH
        do_reset(1'b0, 8'd3, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            push_ev(K_RISE, (i == 1) ? -1 : 4, i);
            push_ev(K_FALL, 4, i);
        end
        push_ev(K_STOP, 4, 5);
        wait_q(2, 100, "run_hp3");
        halt = 1'b1;
        wait_q(0, 40, "run_halt_stop");
        tick(10);
        chk("halt_parked_clk", cpu_clk, 0);
        chk("halt_parked_running", running, 0);

        // halt release: rise on the next cycle, halt again on cycle 1 of HIGH
        push_ev(K_RISE, -1, 6);
        push_ev(K_FALL, 4, 6);
        push_ev(K_STOP, 4, 6);
        halt = 1'b0;
        tick(1);
        chk("resume_latency_rise", clk_rise, 1);
        chk("resume_latency_clk", cpu_clk, 1);
        halt = 1'b1;
        wait_q(0, 40, "halt_cycle1");
        tick(5);

        // minimum divide, 17 periods so the 4-bit count wraps
        do_reset(1'b0, 8'd0, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            push_ev(K_RISE, (i == 1) ? -1 : 1, i % 16);
            push_ev(K_FALL, 1, i % 16);
        end
        push_ev(K_STOP, 1, 1);
        wait_q(2, 100, "hp0_wrap");
        halt = 1'b1;
        wait_q(0, 20, "hp0_stop");
        tick(5);

        // debounced step, hp=2: bounce then hold 10 cycles -> one pulse
        do_reset(1'b1, 8'd2, 1'b0);
        push_ev(K_RISE, -1, 1);
        push_ev(K_FALL, 3, 1);
        push_ev(K_STOP, 3, 1);
        step_btn = 1'b1; tick(1);
        step_btn = 1'b0; tick(1);
        step_btn = 1'b1; tick(10);
        step_btn = 1'b0;
        wait_q(0, 40, "step_hp2");
        tick(15);
        chk("step_parked_clk", cpu_clk, 0);

        // step, hp=9: a second press during the pulse is discarded
        half_period = 8'd9;
        push_ev(K_RISE, -1, 2);
        push_ev(K_FALL, 10, 2);
        push_ev(K_STOP, 10, 2);
        step_btn = 1'b1; tick(6);
        step_btn = 1'b0; tick(6);
        step_btn = 1'b1; tick(8);
        step_btn = 1'b0;
        wait_q(0, 60, "step_second_press");
        tick(20);
        chk("no_queued_press", running, 0);

        // a press after returning to STOP is accepted again
        push_ev(K_RISE, -1, 3);
        push_ev(K_FALL, 10, 3);
        push_ev(K_STOP, 10, 3);
        step_btn = 1'b1; tick(6);
        step_btn = 1'b0;
        wait_q(0, 60, "step_third_press");
        tick(10);

        // mode 0->1 and hp 3->1 mid-HIGH: HIGH stays 4, LOW uses new hp
        do_reset(1'b0, 8'd3, 1'b0);
        push_ev(K_RISE, -1, 1);
        push_ev(K_FALL, 4, 1);
        push_ev(K_STOP, 2, 1);
        wait_q(2, 20, "mode_switch_rise");
        mode        = 1'b1;
        half_period = 8'd1;
        wait_q(0, 20, "mode_switch_stop");
        tick(10);

        // reset during HIGH aborts the phase immediately
        do_reset(1'b0, 8'd3, 1'b0);
        push_ev(K_RISE, -1, 1);
        wait_q(0, 20, "pre_reset_rise");
        chk("mid_high_clk", cpu_clk, 1);
        do_reset(1'b1, 8'd3, 1'b1);
        tick(5);

        chk("queue_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
Next-generation CPU clock controller for the 8-bit CPU. It generates a registered 50%-duty cpu_clk from sys_clk with a run-time programmable half-period. It supports free-run and single-step modes, with an on-chip synchroniser and debouncer for the step button. It honours the CPU halt request, never emits runt pulses, and provides rise/fall enable strobes and a cycle counter for the debug display.

Parameters:
DIV_WIDTH, 24, width of half_period input
DB_CYCLES, 250000, consecutive stable sys_clk cycles needed to accept a step-button level change (>=1)
CNT_WIDTH, 16, width of cycle_count

Ports:
sys_clk  in  1  system clock; all logic on posedge
sys_rst_n  in  1  synchronous active-low reset
mode  in  1  0 = run (continuous), 1 = step (manual)
step_btn  in  1  raw asynchronous push-button, active-high
halt  in  1  CPU halt request, level
half_period  in  DIV_WIDTH  each cpu_clk phase lasts half_period+1 sys_clk cycles
cpu_clk  out  1  generated CPU clock, registered
clk_rise  out  1  1-cycle strobe on the first sys_clk cycle of each cpu_clk high phase
clk_fall  out  1  1-cycle strobe on the first sys_clk cycle of each cpu_clk low phase
running  out  1  1 when state is HIGH or LOW
cycle_count  out  CNT_WIDTH  number of cpu_clk rising edges since reset, wraps to 0

Behaviour:
- Reset (sys_rst_n=0 at posedge): state=STOP, cpu_clk=0, clk_rise=clk_fall=0, running=0, cycle_count=0, phase counter=0, sync flops=0, debounced level=0, debounce counter=0, step_req=0. Reset mid-phase aborts the phase immediately; cpu_clk reads 0 on the next cycle.
- Button path: step_btn -> 2-FF synchroniser -> debouncer. The debounced level takes the synchronised value once it has differed from the current debounced level for DB_CYCLES consecutive cycles; any bounce restarts the count. A 0->1 transition of the debounced level sets step_req.
- step_req is set only when mode=1 and state=STOP; otherwise the press is discarded, with no queuing.
- FSM states: STOP, HIGH, LOW. cpu_clk=1 exactly in HIGH.
- STOP -> HIGH when !halt and (mode=0, or mode=1 and step_req=1). Entering HIGH clears step_req.
- HIGH: the phase counter counts 0..hp, where hp is half_period latched on phase entry. At count=hp -> LOW.
- LOW: counts 0..hp (hp re-latched on entry). At count=hp: go to HIGH if mode=0 and !halt; otherwise go to STOP.
- Phase length is hp+1 cycles, so hp=0 gives cpu_clk toggling every sys_clk cycle. A half_period change takes effect at the next phase boundary only.
- A started high phase is always completed by its low phase. halt, a mode change or a step press during HIGH/LOW never truncates a phase.
- halt asserted in STOP: remain in STOP. halt deasserted: resume per mode on the next cycle.
- Step mode produces exactly one full cpu_clk period per accepted press: HIGH for hp+1 cycles, then LOW for hp+1 cycles, then STOP.
- Latency: from the STOP exit condition true at posedge N, cpu_clk=1 and clk_rise=1 are visible after posedge N+1.
- clk_rise/clk_fall are registered and coincide with the first cycle cpu_clk shows its new value.
- cycle_count increments on each clk_rise. It wraps from 2^CNT_WIDTH-1 to 0.

Test Plan:
- Run, free clock: mode=0, hp=3, halt=0 after reset -> cpu_clk high 4 / low 4 cycles repeating; clk_rise every 8 cycles; cycle_count=5 after 5 rises.
- Minimum divide: hp=0, mode=0 -> cpu_clk toggles every cycle; clk_rise and clk_fall alternate every cycle.
- Debounced step: DB_CYCLES=4, mode=1, hp=2. Button bounces 1-0-1 for 2 cycles, then holds 1 for 10 cycles -> exactly one pulse (3 high, 3 low), then STOP; cycle_count +1. A second press during the pulse is ignored.
- Halt: mode=0, hp=3, halt rises on cycle 1 of HIGH -> the high phase completes its 4 cycles and the low phase its 4 cycles, then STOP with cpu_clk=0. halt=0 -> clk_rise on the next cycle.
- Mode switch mid-phase: mode 0->1 during HIGH -> full HIGH then LOW, then STOP; no pulse shorter than hp+1 cycles.
- Reset and wrap: CNT_WIDTH=4, 16 rises -> cycle_count wraps 15->0. sys_rst_n=0 during HIGH -> next cycle cpu_clk=0, state STOP, count=0.
